// File: rtl/dbus_ram_responder.sv
// Data-bus RAM responder: serves one request at a time after a programmable latency,
// applies byte strobes on writes and flags out-of-range or misaligned accesses.
package dbus_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_ram_responder_chk (
  input logic        clk,
  input logic        reset,
  input logic        addr_ok,
  input logic        data_ok,
  input logic        err,
  input logic [63:0] data
);
  a_ok_pair: assert property (@(posedge clk) disable iff (reset) data_ok == addr_ok);
  a_single_pulse: assert property (@(posedge clk) disable iff (reset) data_ok |=> !data_ok);
  a_err_zero_data: assert property (@(posedge clk) disable iff (reset)
    err |-> (data_ok && (data == 64'd0)));
endmodule

module dbus_ram_responder
  import dbus_pkg::*;
#(
  parameter int          DEPTH     = 512,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);
  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [63:0] addr_r;
  msize_t      size_r;
  logic [7:0]  strobe_r;
  logic [63:0] wdata_r;
  logic        addr_ok_r;
  logic        data_ok_r;
  logic        err_r;
  logic [63:0] rdata_r;
  logic [63:0] mem_r [DEPTH];

  logic [63:0] sel_addr_s;
  msize_t      sel_size_s;
  logic [63:0] off_s;
  logic [AW-1:0] idx_s;
  logic        fault_s;
  logic        enter_resp_s;
  logic        commit_s;

  function automatic logic misaligned(input logic [2:0] lo, input msize_t size);
    logic mis;
    case (size)
      MSIZE2:  mis = lo[0];
      MSIZE4:  mis = |lo[1:0];
      MSIZE8:  mis = |lo[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Address decode; in IDLE the live request is decoded so LATENCY=0 can answer next cycle.
  always_comb begin
    sel_addr_s = addr_r;
    sel_size_s = size_r;
    if (state_r == IDLE) begin
      sel_addr_s = dreq.addr;
      sel_size_s = dreq.size;
    end else begin
      sel_addr_s = addr_r;
      sel_size_s = size_r;
    end
    off_s   = sel_addr_s - BASE_ADDR;
    idx_s   = off_s[AW+2:3];
    fault_s = (sel_addr_s < BASE_ADDR) || ((off_s >> 3) >= 64'(DEPTH)) ||
              misaligned(sel_addr_s[2:0], sel_size_s);
  end

  // Transition-into-RESP and write-commit qualifiers.
  always_comb begin
    enter_resp_s = 1'b0;
    if (state_r == IDLE) begin
      enter_resp_s = dreq.valid && (LATENCY == 0);
    end else if (state_r == WAIT) begin
      enter_resp_s = dreq.valid && (cnt_r == 4'd1);
    end else begin
      enter_resp_s = 1'b0;
    end
    commit_s = (state_r == RESP) && (strobe_r != 8'd0) && !fault_s;
  end

  // Request FSM with registered handshake, data and error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      addr_r    <= 64'd0;
      size_r    <= MSIZE1;
      strobe_r  <= 8'd0;
      wdata_r   <= 64'd0;
      addr_ok_r <= 1'b0;
      data_ok_r <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= 64'd0;
    end else begin
      addr_ok_r <= enter_resp_s;
      data_ok_r <= enter_resp_s;
      err_r     <= enter_resp_s && fault_s;
      if (enter_resp_s) begin
        rdata_r <= fault_s ? 64'd0 : mem_r[idx_s];
      end
      case (state_r)
        IDLE: begin
          if (dreq.valid) begin
            addr_r   <= dreq.addr;
            size_r   <= dreq.size;
            strobe_r <= dreq.strobe;
            wdata_r  <= dreq.data;
            cnt_r    <= LAT4;
            state_r  <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          // Requester withdrew: drop the transaction without a response or write.
          if (!dreq.valid) begin
            cnt_r   <= 4'd0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
              state_r <= RESP;
            end
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Byte-lane write commit on leaving RESP; storage intentionally survives reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_r[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  assign dresp.addr_ok = addr_ok_r;
  assign dresp.data_ok = data_ok_r;
  assign dresp.data    = rdata_r;
  assign err           = err_r;

  dbus_ram_responder_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .addr_ok (addr_ok_r),
    .data_ok (data_ok_r),
    .err     (err_r),
    .data    (rdata_r)
  );
endmodule

// File: doc/dbus_ram_responder.md
# dbus_ram_responder

Responder end of the data bus (`dbus_req_t` / `dbus_resp_t`). It models the data memory that the memory stage drives: it accepts one request at a time, waits a programmable latency, and then returns a single-cycle `addr_ok`/`data_ok` handshake. Reads return the full aligned doubleword, and the requester does lane extraction and extension. Writes apply the byte strobe to the doubleword. It replaces the external memory in core-level simulation and serves as the bus target for pipeline memory-stage tests.

## Interface
Parameters:
- `DEPTH`, 512: number of 64-bit doublewords stored; a power of two.
- `LATENCY`, 2: wait cycles between request acceptance and response, range 0..15.
- `BASE_ADDR`, 64'h8000_0000: byte address of doubleword 0; 8-byte aligned.

Ports:
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `dreq`, input, `dbus_req_t`: fields `valid`, `addr`, `size` (`msize_t`), `strobe` (8 bits), `data` (64 bits).
- `dresp`, output, `dbus_resp_t`: fields `addr_ok`, `data_ok`, `data` (64 bits).
- `err`, output, 1: high in the response cycle of a faulting request.

## Operation
- States: `IDLE`, `WAIT`, `RESP`.
- **IDLE**
  - If `dreq.valid` is high, latch `addr`, `size`, `strobe` and `data` into request registers.
  - Load the counter with `LATENCY`.
  - Go to `WAIT`, or go straight to `RESP` when `LATENCY`=0.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to `RESP` on the edge where the counter is 1 (the counter reaches 0).
  - If `dreq.valid` is sampled low in `WAIT`, abort: go to `IDLE`, commit no write, give no response.
- **Response data load.** On the edge entering `RESP`:
  - load the response data register with `mem[idx]`, or with 0 on fault;
  - set the `err` register from the fault check.
- **RESP**
  - `dresp.addr_ok`, `dresp.data_ok` and `err` (when faulting) are high for exactly this one cycle.
  - On the edge leaving `RESP`, a write is committed if `strobe` is not 0 and there is no fault. For each byte lane i with `strobe[i]`=1, `mem[idx][8i+7:8i]` takes `data[8i+7:8i]`.
  - Next state is always `IDLE`.
- **Index and fault.** `idx` = (`addr` − `BASE_ADDR`) >> 3, computed in 64 bits. A request faults if any of these holds:
  - `addr` < `BASE_ADDR`;
  - `idx` ≥ `DEPTH`;
  - `addr` is misaligned for its size: MSIZE2 needs `addr[0]`=0, MSIZE4 needs `addr[1:0]`=0, MSIZE8 needs `addr[2:0]`=0.
- A faulting request still completes the handshake, with `dresp.data`=0, no write and `err`=1.
- **Data and strobe handling**
  - The strobe is applied exactly as given: the responder does not re-derive it from `size`.
  - Read data is never shifted: byte lane i carries byte `addr[2:0]`=i.
- **Unchanging inputs.** Request fields changing after acceptance are ignored, because the latched copies are used.
- **Reset state.** Asynchronous reset gives: state `IDLE`, counter 0, `dresp.addr_ok`=0, `dresp.data_ok`=0, `dresp.data`=0, `err`=0. Memory contents are not cleared.

## Timing
- **Latency.** A request accepted in IDLE at cycle t is answered in cycle t+1+`LATENCY`: cycle t+1 when `LATENCY`=0, cycle t+3 for the default.
- **Throughput.**
  - The state returns to `IDLE` in cycle t+2+`LATENCY`; a request valid in that cycle is accepted then.
  - Peak throughput is one transaction per `LATENCY`+2 cycles.
  - The requester must deassert `valid` or present the next request in the cycle after `data_ok`. A still-high `valid` in that cycle is taken as a new request.
- **Write visibility.** A write is visible to a read accepted at any later IDLE cycle.
- **Outputs.** `dresp` and `err` are registered: they have no combinational path from `dreq`.
- **Reset mid-operation.** Reset in `WAIT` or `RESP` aborts the transaction. No write is committed, and the outputs drop to 0 immediately (asynchronously).

## Test plan
- **Store then load.** `LATENCY`=2. SD to 0x8000_0010 with data 0x1122_3344_5566_7788 and strobe 0xFF, then LD from the same address.
  - `data_ok` pulses 3 cycles after each acceptance.
  - The LD returns 0x1122_3344_5566_7788 with `err`=0.
- **Byte strobe.** SB to 0x8000_0013, strobe 0x08, data 0x0000_0000_AA00_0000, then LD from 0x8000_0010.
  - Result is 0x1122_3344_AA66_7788.
- **Faults.**
  - SW to 0x8000_0012 (misaligned for 4 bytes): `err`=1, data 0, memory unchanged.
  - LD from 0x7FFF_FFF8 (below base): `err`=1, data 0.
  - LD from 0x8000_1000 (`idx`=512 with `DEPTH`=512): `err`=1, data 0.
- **Abort.** Drop `valid` in the first `WAIT` cycle of an SD to 0x8000_0020 with data 0xFFFF_FFFF_FFFF_FFFF.
  - No `data_ok` is produced.
  - A following LD returns the old value.
- **Zero latency and back-to-back.** `LATENCY`=0 with four consecutive LDs, `valid` held high.
  - Responses appear every 2 cycles, each exactly 1 cycle after its acceptance.
- **Reset mid-operation.** Assert `reset` during `RESP` of an SD.
  - `addr_ok`, `data_ok` and `err` go to 0 at once; the state returns to `IDLE`.
  - A following LD shows no write committed.
